// File: rtl/vga_timing_ctrl_pkg.sv
// Shared definitions for the VGA timing controller: region and top-level
// state encodings plus the default 528x628 timing constants.
package vga_timing_ctrl_pkg;

   typedef enum logic [1:0] {
      RG_ACTIVE = 2'd0,
      RG_FRONT  = 2'd1,
      RG_SYNC   = 2'd2,
      RG_BACK   = 2'd3
   } region_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam int DEF_CW       = 10;
   localparam int DEF_H_ACTIVE = 400;
   localparam int DEF_H_FP     = 10;
   localparam int DEF_H_SYNC   = 74;
   localparam int DEF_H_BP     = 44;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 23;

endpackage

// File: rtl/vga_axis_seq.sv
// One display axis: counter plus ACTIVE/FRONT/SYNC/BACK region FSM with
// registered blank/sync decode. clr (or rst) parks the axis at count 0, blanked.
module vga_axis_seq
   import vga_timing_ctrl_pkg::*;
#(
   parameter int   A        = 400,
   parameter int   FP       = 10,
   parameter int   SYNC     = 74,
   parameter int   BP       = 44,
   parameter int   CW       = 10,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic [1:0]    region,
   output logic          blank,
   output logic          sync,
   output logic          wrap
);

   localparam int TOTAL = A + FP + SYNC + BP;
   localparam logic [CW-1:0] END_ACT  = CW'(A - 1);
   localparam logic [CW-1:0] END_FP   = CW'(A + FP - 1);
   localparam logic [CW-1:0] END_SYNC = CW'(A + FP + SYNC - 1);
   localparam logic [CW-1:0] END_BACK = CW'(TOTAL - 1);

   if (A < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_region_len
      $error("vga_axis_seq: every region length must be at least 1");
   end
   if (TOTAL > 2 ** CW) begin : g_bad_total
      $error("vga_axis_seq: axis total does not fit in CW bits");
   end

   logic [CW-1:0] count_r, count_nxt_s;
   region_t       region_r, region_nxt_s;
   logic          blank_r, blank_nxt_s;
   logic          sync_r, sync_nxt_s;
   logic          parked_r, parked_nxt_s;
   logic          wrap_s;

   // A parked axis never wraps, so the vertical axis only steps from live lines.
   assign wrap_s = step & ~parked_r & (count_r == END_BACK);

   // Next-state: park, unpark onto count 0, or advance count and region.
   always_comb begin
      count_nxt_s  = count_r;
      region_nxt_s = region_r;
      blank_nxt_s  = blank_r;
      sync_nxt_s   = sync_r;
      parked_nxt_s = parked_r;
      if (clr) begin
         count_nxt_s  = {CW{1'b0}};
         region_nxt_s = RG_ACTIVE;
         blank_nxt_s  = 1'b1;
         sync_nxt_s   = ~SYNC_POL;
         parked_nxt_s = 1'b1;
      end else if (step && parked_r) begin
         count_nxt_s  = {CW{1'b0}};
         region_nxt_s = RG_ACTIVE;
         blank_nxt_s  = 1'b0;
         sync_nxt_s   = ~SYNC_POL;
         parked_nxt_s = 1'b0;
      end else if (step) begin
         count_nxt_s = wrap_s ? {CW{1'b0}} : count_r + CW'(1'b1);
         case (region_r)
            RG_ACTIVE: begin
               if (count_r == END_ACT) begin
                  region_nxt_s = RG_FRONT;
                  blank_nxt_s  = 1'b1;
               end else begin
                  region_nxt_s = RG_ACTIVE;
               end
            end
            RG_FRONT: begin
               if (count_r == END_FP) begin
                  region_nxt_s = RG_SYNC;
                  sync_nxt_s   = SYNC_POL;
               end else begin
                  region_nxt_s = RG_FRONT;
               end
            end
            RG_SYNC: begin
               if (count_r == END_SYNC) begin
                  region_nxt_s = RG_BACK;
                  sync_nxt_s   = ~SYNC_POL;
               end else begin
                  region_nxt_s = RG_SYNC;
               end
            end
            RG_BACK: begin
               if (wrap_s) begin
                  region_nxt_s = RG_ACTIVE;
                  blank_nxt_s  = 1'b0;
               end else begin
                  region_nxt_s = RG_BACK;
               end
            end
            default: begin
               region_nxt_s = RG_ACTIVE;
               blank_nxt_s  = 1'b1;
               sync_nxt_s   = ~SYNC_POL;
            end
         endcase
      end else begin
         parked_nxt_s = parked_r;
      end
   end

   // Axis state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r  <= {CW{1'b0}};
         region_r <= RG_ACTIVE;
         blank_r  <= 1'b1;
         sync_r   <= ~SYNC_POL;
         parked_r <= 1'b1;
      end else begin
         count_r  <= count_nxt_s;
         region_r <= region_nxt_s;
         blank_r  <= blank_nxt_s;
         sync_r   <= sync_nxt_s;
         parked_r <= parked_nxt_s;
      end
   end

   assign count  = count_r;
   assign region = region_r;
   assign blank  = blank_r;
   assign sync   = sync_r;
   assign wrap   = wrap_s;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: horizontal and vertical axis sequencers under an
// IDLE/SCAN FSM that starts and parks the display on frame boundaries.
module vga_timing_ctrl
   import vga_timing_ctrl_pkg::*;
#(
   parameter int   CW       = DEF_CW,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   input  logic          run,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          hblank,
   output logic          vblank,
   output logic          blank,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start,
   output logic          busy
);

   state_t     state_r, state_nxt_s;
   logic       start_s, stop_s, frame_end_s;
   logic       h_step_s, v_step_s, h_wrap_s, v_wrap_s;
   logic [1:0] h_region_s, v_region_s;
   logic       line_start_r, frame_start_r, busy_r;

   assign start_s     = (state_r == ST_IDLE) & pix_en & run;
   assign h_step_s    = pix_en & ((state_r == ST_SCAN) | run);
   assign v_step_s    = h_wrap_s | start_s;
   assign frame_end_s = v_wrap_s & (h_region_s == RG_BACK) & (v_region_s == RG_BACK);
   // Parking both axes on the frame wrap leaves them blanked at (0,0).
   assign stop_s      = frame_end_s & ~run;

   vga_axis_seq #(
      .A(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW), .SYNC_POL(SYNC_POL)
   ) u_h_axis (
      .clk(clk), .rst(rst), .step(h_step_s), .clr(stop_s),
      .count(hcount), .region(h_region_s), .blank(hblank), .sync(hsync), .wrap(h_wrap_s)
   );

   vga_axis_seq #(
      .A(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW), .SYNC_POL(SYNC_POL)
   ) u_v_axis (
      .clk(clk), .rst(rst), .step(v_step_s), .clr(stop_s),
      .count(vcount), .region(v_region_s), .blank(vblank), .sync(vsync), .wrap(v_wrap_s)
   );

   // IDLE/SCAN next-state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_nxt_s = ST_SCAN;
            else         state_nxt_s = ST_IDLE;
         end
         ST_SCAN: begin
            if (stop_s) state_nxt_s = ST_IDLE;
            else        state_nxt_s = ST_SCAN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state, strobes and busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         line_start_r  <= start_s | (h_wrap_s & ~stop_s);
         frame_start_r <= start_s | (frame_end_s & ~stop_s);
         busy_r        <= (state_nxt_s == ST_SCAN);
      end
   end

   assign blank       = hblank | vblank | ~busy_r;
   assign line_start  = line_start_r;
   assign frame_start = frame_start_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl: two parameterizations checked every
// clock against an arithmetic (modulo-count) reference model.
module tb_vga_timing_ctrl;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, cw;
      bit pol;
   } tp_t;

   typedef struct {
      int h, v;
      bit scan, ls, fs;
   } ms_t;

   logic clk = 1'b0;
   logic rst, pix_en, run;

   logic [9:0] hcount_a, vcount_a;
   logic       hblank_a, vblank_a, blank_a, hsync_a, vsync_a, line_start_a, frame_start_a, busy_a;
   logic [3:0] hcount_b, vcount_b;
   logic       hblank_b, vblank_b, blank_b, hsync_b, vsync_b, line_start_b, frame_start_b, busy_b;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vga_timing_ctrl #(
      .CW(10), .H_ACTIVE(400), .H_FP(10), .H_SYNC(74), .H_BP(44),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
   ) u_dut_a (
      .clk(clk), .rst(rst), .pix_en(pix_en), .run(run),
      .hcount(hcount_a), .vcount(vcount_a), .hblank(hblank_a), .vblank(vblank_a),
      .blank(blank_a), .hsync(hsync_a), .vsync(vsync_a),
      .line_start(line_start_a), .frame_start(frame_start_a), .busy(busy_a)
   );

   vga_timing_ctrl #(
      .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
   ) u_dut_b (
      .clk(clk), .rst(rst), .pix_en(pix_en), .run(run),
      .hcount(hcount_b), .vcount(vcount_b), .hblank(hblank_b), .vblank(vblank_b),
      .blank(blank_b), .hsync(hsync_b), .vsync(vsync_b),
      .line_start(line_start_b), .frame_start(frame_start_b), .busy(busy_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
   endtask

   // Reference: display position as plain modulo counts plus a scanning flag.
   function automatic ms_t mstep(ms_t s, tp_t p, bit r, bit pe, bit rn);
      ms_t n;
      int  ht, vt;
      bit  hw, fw;
      n    = s;
      n.ls = 1'b0;
      n.fs = 1'b0;
      ht   = p.ha + p.hf + p.hs + p.hb;
      vt   = p.va + p.vf + p.vs + p.vb;
      hw   = (s.h == ht - 1);
      fw   = hw && (s.v == vt - 1);
      if (r) begin
         n.h = 0; n.v = 0; n.scan = 1'b0;
      end else if (pe && !s.scan) begin
         if (rn) begin
            n.h = 0; n.v = 0; n.scan = 1'b1; n.ls = 1'b1; n.fs = 1'b1;
         end
      end else if (pe) begin
         if (fw && !rn) begin
            n.h = 0; n.v = 0; n.scan = 1'b0;
         end else begin
            n.h  = (s.h + 1) % ht;
            n.v  = hw ? (s.v + 1) % vt : s.v;
            n.ls = hw;
            n.fs = fw;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] mexp(ms_t s, tp_t p);
      logic hb, vb, hs_on, vs_on, hs, vs;
      hb    = !s.scan || (s.h >= p.ha);
      vb    = !s.scan || (s.v >= p.va);
      hs_on = s.scan && (s.h >= p.ha + p.hf) && (s.h < p.ha + p.hf + p.hs);
      vs_on = s.scan && (s.v >= p.va + p.vf) && (s.v < p.va + p.vf + p.vs);
      hs    = hs_on ? p.pol : !p.pol;
      vs    = vs_on ? p.pol : !p.pol;
      return (32'(s.h) << (p.cw + 8)) | (32'(s.v) << 8) |
             {24'd0, hb, vb, hb | vb | !s.scan, hs, vs, s.ls, s.fs, s.scan};
   endfunction

   initial begin
      tp_t pa, pb;
      ms_t sa, sb;
      bit  rst_done;
      pa = '{ha: 400, hf: 10, hs: 74, hb: 44, va: 6, vf: 1, vs: 2, vb: 1, cw: 10, pol: 1'b1};
      pb = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1, cw: 4, pol: 1'b0};
      sa = '{h: 0, v: 0, scan: 1'b0, ls: 1'b0, fs: 1'b0};
      sb = sa;
      rst_done = 1'b0;
      rst = 1'b1; pix_en = 1'b1; run = 1'b1;

      for (int cyc = 0; cyc < 60000; cyc++) begin
         if (cyc < 4) begin
            rst = 1'b1; pix_en = 1'b1; run = 1'b1;
         end else if (cyc < 11000) begin
            // Reset mid-frame while A sits in both hsync and vsync.
            rst = 1'b0; pix_en = 1'b1; run = 1'b1;
            if (!rst_done && sa.scan && sa.h == 450 && sa.v == 7) begin
               check("sync_before_rst", {30'd0, hsync_a, vsync_a}, 32'd3);
               rst = 1'b1;
               rst_done = 1'b1;
            end
         end else if (cyc < 27000) begin
            rst = 1'b0; pix_en = (cyc % 3 == 0); run = 1'b1;
         end else if (cyc < 33000) begin
            rst = 1'b0; pix_en = 1'b1; run = 1'b0;
            if (cyc == 32999) check("parked_a", {30'd0, busy_a, blank_a}, 32'd1);
         end else begin
            pix_en = ($urandom_range(3, 0) != 0);
            rst    = ($urandom_range(4999, 0) == 0);
            if (cyc == 33000) run = 1'b1;
            else if ($urandom_range(2999, 0) == 0) run = ~run;
         end
         sa = mstep(sa, pa, rst, pix_en, run);
         sb = mstep(sb, pb, rst, pix_en, run);
         @(posedge clk);
         @(negedge clk);
         check("dut_a", {4'd0, hcount_a, vcount_a, hblank_a, vblank_a, blank_a, hsync_a,
                         vsync_a, line_start_a, frame_start_a, busy_a}, mexp(sa, pa));
         check("dut_b", {16'd0, hcount_b, vcount_b, hblank_b, vblank_b, blank_b, hsync_b,
                         vsync_b, line_start_b, frame_start_b, busy_b}, mexp(sb, pb));
      end
      check("mid_frame_rst_seen", {31'd0, rst_done}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
